// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low segment codes, scan slot
// encoding and digit-enable helper, reused by every display block.
package ssd_pkg;

  // Segment codes {a,b,c,d,e,f,g}, active-low (0 = segment lit).
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Full 8-bit pattern with every segment and the decimal point dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // All digit enables inactive (active-low).
  localparam logic [3:0] CTL_OFF = 4'b1111;

  // Scan position; SLOT0 is the rightmost digit.
  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_e;

  // Active-low one-cold digit enable for a scan slot.
  function automatic logic [3:0] ctl_for(input slot_e s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/bcd2ssd.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show "F".
module bcd2ssd
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the active-low segment pattern.
  always_comb begin
    // NOTE: every path assigns seg, so no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with prescaler,
// frame-aligned shadow registers, ghost blanking, enable gating and
// leading-zero blanking. All outputs are registered.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic [3:0]  dp,
  input  logic        en,
  input  logic        lzb,
  output logic [7:0]  ssd_seg,
  output logic [3:0]  ssd_ctl,
  output logic        frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt, cnt_nx;
  slot_e         idx, idx_nx;
  logic [15:0]   sh_val, sh_val_nx;
  logic [3:0]    sh_dp, sh_dp_nx;
  logic          tick, wrap;
  logic [3:0]    digit;
  logic          lead_blank;
  logic [6:0]    seg7;
  logic [7:0]    seg_nx;
  logic [3:0]    ctl_nx;

  // Next-state of prescaler, scan slot and shadow, plus the output pattern
  // for the slot being entered, so outputs change on the same edge as cnt/idx.
  always_comb begin
    tick      = (cnt == CNT_LAST);
    wrap      = tick && (idx == SLOT3);
    cnt_nx    = tick ? '0 : cnt + 1'b1;
    idx_nx    = tick ? slot_e'(idx + 2'd1) : idx;
    sh_val_nx = wrap ? val : sh_val;
    sh_dp_nx  = wrap ? dp  : sh_dp;

    digit      = sh_val_nx[3:0];
    lead_blank = 1'b0;
    case (idx_nx)
      SLOT0: digit = sh_val_nx[3:0];
      SLOT1: begin
        digit      = sh_val_nx[7:4];
        lead_blank = (sh_val_nx[15:4] == 12'h000);
      end
      SLOT2: begin
        digit      = sh_val_nx[11:8];
        lead_blank = (sh_val_nx[15:8] == 8'h00);
      end
      SLOT3: begin
        digit      = sh_val_nx[15:12];
        lead_blank = (sh_val_nx[15:12] == 4'h0);
      end
      default: ;
    endcase

    seg_nx = {(lzb && lead_blank) ? SEG_OFF : seg7, ~sh_dp_nx[idx_nx]};
    ctl_nx = (!en || (cnt_nx < CNT_BLNK)) ? CTL_OFF : ctl_for(idx_nx);
  end

  bcd2ssd u_dec (
    .bcd (digit),
    .seg (seg7)
  );

  // Registered scan state, shadow and outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: only a handful of flops here, so all of them are reset,
    // including the shadow that feeds the first displayed frame.
    if (rst) begin
      cnt         <= '0;
      idx         <= SLOT0;
      sh_val      <= '0;
      sh_dp       <= '0;
      ssd_ctl     <= CTL_OFF;
      ssd_seg     <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      sh_val      <= sh_val_nx;
      sh_dp       <= sh_dp_nx;
      ssd_ctl     <= ctl_nx;
      ssd_seg     <= seg_nx;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1.
// Expected slot patterns are pushed to a scoreboard when stimulus is set
// and popped as the DUT scans each frame. Outputs sampled on negedge.
module tb_ssd_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int TIMEOUT   = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val;
  logic [3:0]  dp;
  logic        en;
  logic        lzb;
  logic [7:0]  ssd_seg;
  logic [3:0]  ssd_ctl;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  ssd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .val         (val),
    .dp          (dp),
    .en          (en),
    .lzb         (lzb),
    .ssd_seg     (ssd_seg),
    .ssd_ctl     (ssd_ctl),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference segment table, active-low {a..g}.
  function automatic logic [6:0] ref_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b0111000;
    endcase
  endfunction

  // Push the four expected slots of a frame holding v/d, displayed with lz.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic lz);
    exp_t e;
    logic [3:0] nib;
    bit higher_zero;
    for (int k = 0; k < 4; k++) begin
      nib = v[4*k +: 4];
      higher_zero = 1'b1;
      for (int j = k; j < 4; j++)
        if (v[4*j +: 4] != 4'h0) higher_zero = 1'b0;
      e.ctl = 4'b1111;
      e.ctl[k] = 1'b0;
      e.seg[7:1] = (lz && k != 0 && higher_zero) ? 7'b1111111 : ref_code(nib);
      e.seg[0] = ~d[k];
      sb.push_back(e);
    end
  endtask

  // Advance to the cycle showing frame_start, bounded.
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < TIMEOUT);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", frame_start, n);
    end
  endtask

  // Compare a whole frame against the scoreboard, starting in the
  // frame_start cycle. Optionally changes val at the start of slot 2.
  task automatic check_frame(input string name, input bit do_mid, input logic [15:0] mid_val);
    exp_t e;
    logic [12:0] act, req;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty at slot %0d", name, s);
        return;
      end
      e = sb.pop_front();
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (!(s == 0 && c == 0)) @(negedge clk);
        if (do_mid && s == 2 && c == 0) val = mid_val;
        req = {(s == 0 && c == 0), (c < BLANK_CYC) ? 4'b1111 : e.ctl, e.seg};
        act = {frame_start, ssd_ctl, ssd_seg};
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL %s slot%0d cyc%0d: fs/ctl/seg=%b/%b/%b required %b/%b/%b",
                   name, s, c, act[12], act[11:8], act[7:0], req[12], req[11:8], req[7:0]);
        end
      end
    end
  endtask

  // Called on the negedge right after rst drops; checks the reset state,
  // the zero shadow and timing of the first slot change and frame.
  task automatic post_reset_checks(input string name);
    int n = 0;
    checks++;
    if ({frame_start, ssd_ctl, ssd_seg} !== {1'b0, 4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL %s_state: fs/ctl/seg=%b/%b/%h required 0/1111/ff", name, frame_start, ssd_ctl, ssd_seg);
    end
    @(negedge clk); n = 1;
    checks++;
    if ({ssd_ctl, ssd_seg} !== {4'b1110, 8'b0000001_1}) begin
      errors++;
      $display("FAIL %s_cyc1: ctl/seg=%b/%b required 1110/00000011", name, ssd_ctl, ssd_seg);
    end
    repeat (4) @(negedge clk); n = 5;
    checks++;
    if ({ssd_ctl, ssd_seg} !== {4'b1101, 8'b0000001_1}) begin
      errors++;
      $display("FAIL %s_first_tick: ctl/seg=%b/%b required 1101/00000011", name, ssd_ctl, ssd_seg);
    end
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < TIMEOUT);
    checks++;
    if (!(frame_start === 1'b1 && n == 4 * SCAN_DIV)) begin
      errors++;
      $display("FAIL %s_first_frame: frame_start=%b at cycle %0d required 1 at %0d",
               name, frame_start, n, 4 * SCAN_DIV);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    val = 16'h9999;
    dp  = 4'b1111;
    en  = 1'b1;
    lzb = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ssd_ctl, ssd_seg} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL reset_hold: ctl/seg=%b/%h required 1111/ff", ssd_ctl, ssd_seg);
    end
    rst = 1'b0;
    post_reset_checks("reset");
  endtask

  task automatic test_scan();
    val = 16'h1234;
    dp  = 4'b0000;
    push_frame(16'h1234, 4'b0000, 1'b0);
    wait_frame();
    check_frame("scan", 1'b0, 16'h0);
  endtask

  task automatic test_tear_free();
    val = 16'h1234;
    push_frame(16'h1234, 4'b0000, 1'b0);
    wait_frame();
    check_frame("tear_old", 1'b1, 16'h5678);
    push_frame(16'h5678, 4'b0000, 1'b0);
    wait_frame();
    check_frame("tear_new", 1'b0, 16'h0);
  endtask

  task automatic test_lzb();
    lzb = 1'b1;
    val = 16'h0070;
    push_frame(16'h0070, 4'b0000, 1'b1);
    wait_frame();
    check_frame("lzb_0070", 1'b0, 16'h0);
    val = 16'h0000;
    push_frame(16'h0000, 4'b0000, 1'b1);
    wait_frame();
    check_frame("lzb_0000", 1'b0, 16'h0);
    val = 16'h0305;
    dp  = 4'b0100;
    push_frame(16'h0305, 4'b0100, 1'b1);
    wait_frame();
    check_frame("lzb_0305", 1'b0, 16'h0);
    lzb = 1'b0;
  endtask

  task automatic test_invalid_dp();
    val = 16'hA009;
    dp  = 4'b1000;
    push_frame(16'hA009, 4'b1000, 1'b0);
    wait_frame();
    check_frame("invalid_dp", 1'b0, 16'h0);
    val = 16'hFBC8;
    dp  = 4'b0011;
    push_frame(16'hFBC8, 4'b0011, 1'b0);
    wait_frame();
    check_frame("hex_codes", 1'b0, 16'h0);
  endtask

  task automatic test_enable();
    int n;
    wait_frame();
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ssd_ctl !== 4'b1111) begin
        errors++;
        $display("FAIL enable_off cyc%0d: ctl=%b required 1111", i, ssd_ctl);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n = 9;
    checks++;
    if (ssd_ctl !== 4'b1011) begin
      errors++;
      $display("FAIL enable_resume: ctl=%b required 1011", ssd_ctl);
    end
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < TIMEOUT);
    checks++;
    if (!(frame_start === 1'b1 && n == 4 * SCAN_DIV)) begin
      errors++;
      $display("FAIL enable_frame: frame_start=%b at cycle %0d required 1 at %0d",
               frame_start, n, 4 * SCAN_DIV);
    end
  endtask

  task automatic test_rst_mid();
    val = 16'h4321;
    dp  = 4'b0101;
    wait_frame();
    wait_frame();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({frame_start, ssd_ctl, ssd_seg} !== {1'b0, 4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL rst_mid: fs/ctl/seg=%b/%b/%h required 0/1111/ff", frame_start, ssd_ctl, ssd_seg);
    end
    @(negedge clk);
    rst = 1'b0;
    post_reset_checks("rst_mid");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_lzb();
    test_invalid_dp();
    test_enable();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot (min 4).
REQ-002 SHALL have parameter BLANK_CYC, default 2, inter-digit blanking cycles at the start of each slot (less than SCAN_DIV).
REQ-003 SHALL provide clk, input, 1, sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL provide rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL provide val, input, 16, four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 SHALL provide dp, input, 4, decimal-point request per digit, 1 = lit.
REQ-007 SHALL provide en, input, 1, display enable; 0 = all digits off.
REQ-008 SHALL provide lzb, input, 1, leading-zero blanking enable.
REQ-009 SHALL provide ssd_seg, output, 8, active-low segments {a,b,c,d,e,f,g,dp}, with dp at bit 0.
REQ-010 SHALL provide ssd_ctl, output, 4, active-low digit enables; bit k drives digit k.
REQ-011 SHALL provide frame_start, output, 1, single-cycle pulse on the edge where the scan wraps to digit 0.

Function
REQ-012 SHALL use prescaler cnt, counting 0..SCAN_DIV-1 and wrapping to 0; tick = (cnt==SCAN_DIV-1).
REQ-013 SHALL hold scan index idx at 0..3; on each tick idx advances 0->1->2->3->0; no other event changes idx.
REQ-014 SHALL load shadow registers {val,dp} on the edge where idx goes 3->0, asserting frame_start on that same edge; display uses only shadow values (tear-free).
REQ-015 SHALL register ssd_seg and ssd_ctl; they update on the same edge as cnt/idx.
REQ-016 SHALL drive ssd_ctl = 4'b1111 while cnt < BLANK_CYC (ghost blanking), else all ones except bit idx = 0.
REQ-017 SHALL force ssd_ctl = 4'b1111 on the next edge after en=0, with cnt/idx/shadow still running; en=1 resumes at current slot position with no restart.
REQ-018 SHALL decode digit idx to segments: 0=0000001,1=1001111,2=0010010,3=0000110,4=1001100,5=0100100,6=0100000,7=0001111,8=0000000,9=0000100; codes 10-15 show F=0111000.
REQ-019 SHALL drive ssd_seg[0] = ~shadow_dp[idx].
REQ-020 SHALL, with lzb=1, blank digit k (k=3..1) when shadow digit k and all higher digits are 0: segment bits [7:1]=1111111, dp still per REQ-019; digit 0 never blanked; lzb is sampled live, not shadowed.
REQ-021 SHALL keep ssd_seg valid during blanking (shows current idx), while ssd_ctl stays 1111.

Reset
REQ-022 SHALL, while rst=1 at an edge, set: cnt=0, idx=0, shadow val=0, shadow dp=0, ssd_ctl=4'b1111, ssd_seg=8'hFF, frame_start=0.
REQ-023 SHALL have rst override all other inputs, including mid-slot or mid-blank; first tick after release occurs SCAN_DIV cycles later.
REQ-024 SHALL show shadow zero (digit 0 = "0", others "0" or blanked per lzb) for the first frame after reset.

Structure
REQ-025 SHALL define the segment code constants (digits 0-9, F, BLANK=8'hFF) in shared package ssd_pkg, reused by other display blocks.
REQ-026 SHALL implement the decode (REQ-018) as combinational sub-module bcd2ssd (4-bit in, 7-bit out); controller holds prescaler, scan FSM, shadow, blanking, and output registers.
REQ-027 SHALL be 120-400 lines RTL total; no latches, no derived clocks.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-028 SHALL check reset: rst=1 for 3 cycles, release -> ssd_ctl=1111, ssd_seg=FF; cycle 2 after release ssd_ctl=1110, ssd_seg=0000001_1.
REQ-029 SHALL check scan: val=16'h1234, dp=0 -> after first frame_start, slots show ctl 1110/4 (1001100_1), 1101/3, 1011/2, 0111/1; each ctl low for 3 of 4 cycles.
REQ-030 SHALL check tear-free: change val 16'h1234->16'h5678 mid-frame -> digits keep 1234 until next frame_start, then 5678.
REQ-031 SHALL check LZB: val=16'h0070, lzb=1 -> digit 3 and 2 seg[7:1]=1111111, digit 1 shows 7, digit 0 shows 0; val=16'h0000 -> only digit 0 lit with "0".
REQ-032 SHALL check invalid/dp: val=16'hA009, dp=4'b1000 -> digit 3 seg=0111000_0, digit 0 = 0000100_1.
REQ-033 SHALL check enable/reset mid-op: en=0 for 6 cycles -> ctl=1111, idx keeps advancing; rst mid-blank -> outputs per REQ-022 next edge.
